// File: rtl/avst_arb_if.sv
// Avalon-ST bundle for the packet arbiter: N_PORTS source lanes on the input side, one sink lane out.
// The master modport is the arbiter's view; slave is the view of the surrounding sources and sink.
interface avst_arb_if #(
   parameter int N_PORTS = 4,
   parameter int DATA_W  = 128
);
   logic [N_PORTS-1:0]        in_valid;
   logic [N_PORTS-1:0]        in_sop;
   logic [N_PORTS-1:0]        in_eop;
   logic [N_PORTS*DATA_W-1:0] in_data;
   logic [N_PORTS-1:0]        in_ready;
   logic                      out_valid;
   logic                      out_sop;
   logic                      out_eop;
   logic [DATA_W-1:0]         out_data;
   logic                      out_ready;

   modport master (
      input  in_valid, in_sop, in_eop, in_data, out_ready,
      output in_ready, out_valid, out_sop, out_eop, out_data
   );

   modport slave (
      output in_valid, in_sop, in_eop, in_data, out_ready,
      input  in_ready, out_valid, out_sop, out_eop, out_data
   );
endinterface

// File: rtl/avst_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one Avalon-ST sink among N_PORTS sources.
// Optional per-port packet counters are built when the macro ARB_STATS_EN is defined.
module avst_packet_arbiter #(
   parameter int N_PORTS = 4,
   parameter int DATA_W  = 128,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   avst_arb_if.master         bus,
   output logic [N_PORTS-1:0] grant,
   output logic               busy,
   output logic               err_orphan,
   output logic               err_sop
`ifdef ARB_STATS_EN
   ,
   output logic [N_PORTS*CNT_W-1:0] pkt_cnt
`endif
);

   localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   if (N_PORTS < 2 || N_PORTS > 16 || CNT_W < 1) begin : g_cfg_check
      $error("avst_packet_arbiter: unsupported N_PORTS or CNT_W");
   end

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t             state_q, state_d;
   logic [N_PORTS-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]   gidx_q, gidx_d;
   logic [PTR_W-1:0]   last_q, last_d;
   logic               first_q, first_d;
   logic               err_orphan_q, err_orphan_d;
   logic               err_sop_q, err_sop_d;

   logic [N_PORTS-1:0] req;
   logic [N_PORTS-1:0] orphan;
   logic               found;
   logic [PTR_W-1:0]   winner;
   logic               accept;

   assign req    = bus.in_valid & bus.in_sop;
   assign orphan = bus.in_valid & ~bus.in_sop;

   // Round-robin scan starts just after the last port that completed a packet.
   always_comb begin
      int idx;
      idx    = 0;
      found  = 1'b0;
      winner = last_q;
      for (int k = 1; k <= N_PORTS; k++) begin
         idx = (int'(last_q) + k) % N_PORTS;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      bus.out_valid = 1'b0;
      bus.out_sop   = 1'b0;
      bus.out_eop   = 1'b0;
      bus.out_data  = bus.in_data[gidx_q*DATA_W +: DATA_W];
      bus.in_ready  = '0;
      if (state_q == LOCKED) begin
         bus.out_valid        = bus.in_valid[gidx_q];
         bus.out_sop          = bus.in_sop[gidx_q];
         bus.out_eop          = bus.in_eop[gidx_q];
         bus.in_ready[gidx_q] = bus.out_ready;
      end else begin
         // Orphan beats are swallowed while idle, but never while reset is held.
         bus.in_ready = orphan & {N_PORTS{rst_n}};
      end
   end

   assign accept = bus.out_valid & bus.out_ready;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      gidx_d       = gidx_q;
      last_d       = last_q;
      first_d      = first_q;
      err_orphan_d = 1'b0;
      err_sop_d    = 1'b0;
      case (state_q)
         IDLE: begin
            err_orphan_d = |orphan;
            if (found) begin
               state_d = LOCKED;
               gidx_d  = winner;
               grant_d = {{(N_PORTS-1){1'b0}}, 1'b1} << winner;
               first_d = 1'b1;
            end
         end
         LOCKED: begin
            if (accept) begin
               first_d   = 1'b0;
               err_sop_d = bus.out_sop & ~first_q;
               if (bus.out_eop) begin
                  state_d = IDLE;
                  grant_d = '0;
                  last_d  = gidx_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         gidx_q       <= '0;
         last_q       <= PTR_W'(N_PORTS - 1);
         first_q      <= 1'b0;
         err_orphan_q <= 1'b0;
         err_sop_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         gidx_q       <= gidx_d;
         last_q       <= last_d;
         first_q      <= first_d;
         err_orphan_q <= err_orphan_d;
         err_sop_q    <= err_sop_d;
      end
   end

   assign grant      = grant_q;
   assign busy       = (state_q == LOCKED);
   assign err_orphan = err_orphan_q;
   assign err_sop    = err_sop_q;

`ifdef ARB_STATS_EN
   logic [CNT_W-1:0] cnt_q [N_PORTS];
   logic [CNT_W-1:0] cnt_d [N_PORTS];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      cnt_d = cnt_q;
      if (accept && bus.out_eop) cnt_d[gidx_q] = sat_inc(cnt_q[gidx_q]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_PORTS; i++) cnt_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      pkt_cnt = '0;
      for (int i = 0; i < N_PORTS; i++) pkt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_avst_packet_arbiter.sv
// Randomised bench for avst_packet_arbiter with a packet-level reference model of the arbitration rules.
// Counter checks are active when ARB_STATS_EN is defined.
module tb_avst_packet_arbiter;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int CW = 2;

   typedef struct packed {
      logic          sop;
      logic          eop;
      logic [DW-1:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   avst_arb_if #(.N_PORTS(N), .DATA_W(DW)) bus ();
   logic [N-1:0] grant;
   logic         busy;
   logic         err_orphan;
   logic         err_sop;
`ifdef ARB_STATS_EN
   logic [N*CW-1:0] pkt_cnt;
`endif

   avst_packet_arbiter #(.N_PORTS(N), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .grant      (grant),
      .busy       (busy),
      .err_orphan (err_orphan),
      .err_sop    (err_sop)
`ifdef ARB_STATS_EN
      ,
      .pkt_cnt    (pkt_cnt)
`endif
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference model state: per-source beat streams, current owner (-1 idle), last served port.
   beat_t    q [N][$];
   bit [N-1:0] pres;
   int       owner;
   int       last;
   bit       first;
   bit       exp_orph;
   bit       exp_serr;
   int       cnt [N];
   bit       ordy;
   int       omode;
   int       vprob;
   logic [63:0]  gcode;
   logic [N-1:0] prev_grant;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic add_beat(input int p, input bit s, input bit e, input logic [DW-1:0] d);
      beat_t b;
      b.sop = s; b.eop = e; b.data = d;
      q[p].push_back(b);
   endtask

   task automatic add_pkt(input int p, input int len, input logic [DW-1:0] base, input bit midsop);
      for (int i = 0; i < len; i++)
         add_beat(p, (i == 0) || (midsop && i == 1), i == len - 1, base + DW'(i));
   endtask

   function automatic bit idle_all();
      bit r;
      r = (owner < 0);
      for (int p = 0; p < N; p++) if (q[p].size() != 0) r = 1'b0;
      return r;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < N; p++) begin
         q[p].delete();
         cnt[p] = 0;
      end
      pres = '0; owner = -1; last = N - 1; first = 1'b0;
      exp_orph = 1'b0; exp_serr = 1'b0; prev_grant = '0;
   endtask

   task automatic drive();
      for (int p = 0; p < N; p++) begin
         if (!pres[p] && q[p].size() != 0 && $urandom_range(99) < vprob) pres[p] = 1'b1;
         if (pres[p]) begin
            bus.in_valid[p] = 1'b1;
            bus.in_sop[p]   = q[p][0].sop;
            bus.in_eop[p]   = q[p][0].eop;
            bus.in_data[p*DW +: DW] = q[p][0].data;
         end else begin
            bus.in_valid[p] = 1'b0;
            bus.in_sop[p]   = 1'($urandom);
            bus.in_eop[p]   = 1'($urandom);
            bus.in_data[p*DW +: DW] = DW'($urandom);
         end
      end
      case (omode)
         0:       ordy = 1'b1;
         1:       ordy = ~ordy;
         default: ordy = ($urandom_range(99) < 70);
      endcase
      bus.out_ready = ordy;
   endtask

   // Called with inputs stable: compare outputs, then advance the model past the coming edge.
   task automatic cycle();
      logic [N-1:0]  er, eg;
      logic          ev, es, ee;
      logic [DW-1:0] ed;
      int            win;
      er = '0; eg = '0; ev = 1'b0; es = 1'b0; ee = 1'b0; ed = '0; win = -1;
      if (owner < 0) begin
         for (int p = 0; p < N; p++) if (pres[p] && !q[p][0].sop) er[p] = 1'b1;
      end else begin
         eg[owner] = 1'b1;
         er[owner] = ordy;
         if (pres[owner]) begin
            ev = 1'b1; es = q[owner][0].sop; ee = q[owner][0].eop; ed = q[owner][0].data;
         end
      end
      chk("grant", 64'(grant), 64'(eg));
      chk("busy", 64'(busy), 64'(owner >= 0));
      chk("in_ready", 64'(bus.in_ready), 64'(er));
      chk("out_valid", 64'(bus.out_valid), 64'(ev));
      if (ev) begin
         chk("out_sop", 64'(bus.out_sop), 64'(es));
         chk("out_eop", 64'(bus.out_eop), 64'(ee));
         chk("out_data", 64'(bus.out_data), 64'(ed));
      end
      chk("err_orphan", 64'(err_orphan), 64'(exp_orph));
      chk("err_sop", 64'(err_sop), 64'(exp_serr));
`ifdef ARB_STATS_EN
      begin
         logic [N*CW-1:0] ec;
         for (int p = 0; p < N; p++) ec[p*CW +: CW] = CW'(cnt[p]);
         chk("pkt_cnt", 64'(pkt_cnt), 64'(ec));
      end
`endif
      if (grant != '0 && prev_grant == '0)
         for (int p = 0; p < N; p++) if (grant[p]) gcode = (gcode << 4) | 64'(p + 1);
      prev_grant = grant;

      exp_orph = 1'b0;
      exp_serr = 1'b0;
      if (owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            int p;
            p = (last + k) % N;
            if (win < 0 && pres[p] && q[p][0].sop) win = p;
         end
         for (int p = 0; p < N; p++) if (er[p]) begin
            void'(q[p].pop_front());
            pres[p] = 1'b0;
            exp_orph = 1'b1;
         end
         if (win >= 0) begin owner = win; first = 1'b1; end
      end else if (pres[owner] && ordy) begin
         if (q[owner][0].sop && !first) exp_serr = 1'b1;
         first = 1'b0;
         ee = q[owner][0].eop;
         void'(q[owner].pop_front());
         pres[owner] = 1'b0;
         if (ee) begin
            if (cnt[owner] < (1 << CW) - 1) cnt[owner]++;
            last = owner;
            owner = -1;
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         drive();
         @(negedge clk);
         cycle();
      end
   endtask

   task automatic drain(input string tag, input int limit);
      int c;
      c = 0;
      while (!idle_all() && c < limit) begin
         run(1);
         c++;
      end
      chk({tag, "_done"}, 64'(idle_all()), 64'(1));
      run(2);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
      chk("rst_err_orphan", 64'(err_orphan), 64'(0));
      chk("rst_err_sop", 64'(err_sop), 64'(0));
`ifdef ARB_STATS_EN
      chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
`endif
      model_reset();
      bus.in_valid = '0; bus.in_sop = '0; bus.in_eop = '0; bus.in_data = '0; bus.out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      ordy = 1'b1; omode = 0; vprob = 100; gcode = '0;
      bus.in_valid = '1; bus.in_sop = 4'b0101; bus.in_eop = '0; bus.in_data = '1; bus.out_ready = 1'b1;
      do_reset();

      gcode = '0;
      add_pkt(0, 3, 16'h0100, 1'b0);
      drain("s1", 50);
      chk("s1_order", gcode, 64'h1);

      do_reset();
      gcode = '0;
      add_pkt(0, 2, 16'h0200, 1'b0);
      add_pkt(1, 2, 16'h0210, 1'b0);
      add_pkt(2, 2, 16'h0220, 1'b0);
      drain("s2", 50);
      chk("s2_order", gcode, 64'h123);

      gcode = '0;
      for (int i = 0; i < 2; i++) begin
         add_pkt(3, 1, 16'h0300 + 16'(i), 1'b0);
         add_pkt(1, 1, 16'h0310 + 16'(i), 1'b0);
      end
      drain("s3", 50);
      chk("s3_order", gcode, 64'h4242);

      gcode = '0; omode = 1; ordy = 1'b0;
      add_pkt(2, 4, 16'h0400, 1'b0);
      add_pkt(0, 1, 16'h0410, 1'b0);
      drain("s4", 60);
      chk("s4_order", gcode, 64'h31);

      omode = 0;
      add_beat(1, 1'b0, 1'b0, 16'hDEAD);
      drain("s5", 20);

      add_pkt(2, 8, 16'h0700, 1'b1);
      run(6);
      do_reset();

      for (int i = 0; i < 5; i++) add_pkt(0, 2, 16'h0600 + 16'(i * 16), 1'b0);
      drain("s6", 100);
`ifdef ARB_STATS_EN
      chk("s6_cnt_sat", 64'(pkt_cnt[CW-1:0]), 64'(3));
`endif

      vprob = 60; omode = 2;
      for (int n = 0; n < 6; n++) begin
         for (int p = 0; p < N; p++) begin
            int r;
            r = $urandom_range(9);
            if (r == 0) add_beat(p, 1'b0, 1'($urandom), DW'($urandom));
            add_pkt(p, $urandom_range(1, 4), DW'($urandom), r == 1);
         end
      end
      drain("s8", 3000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
